// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C types and constants for the master controller and address translator
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_AACK,
        ST_WDATA,
        ST_WACK,
        ST_RDATA,
        ST_RNACK,
        ST_STOP
    } state_t;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } qphase_t;

    localparam logic [6:0] VADDR_DEV1 = 7'h48;
    localparam logic [6:0] VADDR_DEV2 = 7'h49;

    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

    // States that clock a data or acknowledge bit with the q0..q3 pattern.
    function automatic logic is_bit_state(input state_t s);
        return (s == ST_ADDR) || (s == ST_AACK) || (s == ST_WDATA) ||
               (s == ST_WACK) || (s == ST_RDATA) || (s == ST_RNACK);
    endfunction

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// rtl/i2c_master_ctrl_if.sv - request/response handshake and open-drain line bundle
interface i2c_master_ctrl_if;

    logic       start;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_in;
    logic       sda_in;

    modport master (
        input  start, addr, rw, wdata, scl_in, sda_in,
        output busy, done, ack_err, rdata, scl_oe, sda_oe
    );

    modport slave (
        output start, addr, rw, wdata, scl_in, sda_in,
        input  busy, done, ack_err, rdata, scl_oe, sda_oe
    );

endinterface

// File: rtl/i2c_master_ctrl_qtick.sv
// rtl/i2c_master_ctrl_qtick.sv - quarter-SCL-period tick and phase generator with stretch hold
module i2c_qtick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    run,
    input  logic    hold,
    output logic    tick,
    output logic    first,
    output qphase_t phase
);

    localparam int              CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // tick marks the final clk of a quarter; first marks its opening clk.
    assign tick  = run && !hold && (cnt == LAST);
    assign first = run && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (run && !hold) begin
            if (cnt == LAST) begin
                cnt   <= '0;
                phase <= qphase_t'(phase + 2'd1);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-master I2C initiator for one-byte write/read transactions
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic               clk,
    input  logic               rst,
    i2c_master_ctrl_if.master  bus
);

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] tx_sr;
    logic [7:0] wdata_q;
    logic       rw_q;
    logic       sda_smp;
    logic       busy_q;
    logic       done_q;
    logic       ack_err_q;
    logic [7:0] rdata_q;
    logic       scl_oe_q;
    logic       sda_oe_q;

    logic       run;
    logic       hold;
    logic       tick;
    logic       first;
    qphase_t    phase;

    assign run  = (state != ST_IDLE);
    // A slave holding SCL low after we release it freezes the quarter count.
    assign hold = (phase == Q2) && !bus.scl_in;

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .hold  (hold),
        .tick  (tick),
        .first (first),
        .phase (phase)
    );

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ack_err = ack_err_q;
    assign bus.rdata   = rdata_q;
    assign bus.scl_oe  = scl_oe_q;
    assign bus.sda_oe  = sda_oe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            sda_smp   <= NACK_BIT;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rdata_q   <= '0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (first && phase == Q3)
                sda_smp <= bus.sda_in;

            if (state == ST_IDLE) begin
                if (bus.start) begin
                    state     <= ST_START;
                    busy_q    <= 1'b1;
                    tx_sr     <= {bus.addr, bus.rw};
                    rw_q      <= bus.rw;
                    wdata_q   <= bus.wdata;
                    rdata_q   <= '0;
                    ack_err_q <= 1'b0;
                    bit_cnt   <= '0;
                    scl_oe_q  <= 1'b0;
                    sda_oe_q  <= 1'b0;
                end
            end else if (tick) begin
                // Outputs are set at the tick that opens the following quarter.
                case (phase)
                    Q0: begin
                        if (state == ST_STOP)
                            scl_oe_q <= 1'b0;
                    end
                    Q1: begin
                        if (state == ST_START)
                            sda_oe_q <= 1'b1;
                        else if (state == ST_STOP)
                            sda_oe_q <= 1'b0;
                        else if (is_bit_state(state))
                            scl_oe_q <= 1'b0;
                    end
                    Q3: begin
                        scl_oe_q <= 1'b1;
                        case (state)
                            ST_START: begin
                                state    <= ST_ADDR;
                                bit_cnt  <= '0;
                                sda_oe_q <= ~tx_sr[7];
                            end
                            ST_ADDR, ST_WDATA: begin
                                if (bit_cnt == 4'd7) begin
                                    state    <= (state == ST_ADDR) ? ST_AACK : ST_WACK;
                                    bit_cnt  <= 4'd8;
                                    sda_oe_q <= 1'b0;
                                end else begin
                                    bit_cnt  <= bit_cnt + 1'b1;
                                    tx_sr    <= {tx_sr[6:0], 1'b0};
                                    sda_oe_q <= ~tx_sr[6];
                                end
                            end
                            ST_AACK: begin
                                if (sda_smp == ACK_BIT) begin
                                    bit_cnt <= '0;
                                    if (rw_q) begin
                                        state    <= ST_RDATA;
                                        sda_oe_q <= 1'b0;
                                    end else begin
                                        state    <= ST_WDATA;
                                        tx_sr    <= wdata_q;
                                        sda_oe_q <= ~wdata_q[7];
                                    end
                                end else begin
                                    ack_err_q <= 1'b1;
                                    state     <= ST_STOP;
                                    sda_oe_q  <= 1'b1;
                                end
                            end
                            ST_WACK: begin
                                if (sda_smp == NACK_BIT)
                                    ack_err_q <= 1'b1;
                                state    <= ST_STOP;
                                sda_oe_q <= 1'b1;
                            end
                            ST_RDATA: begin
                                rdata_q  <= {rdata_q[6:0], sda_smp};
                                sda_oe_q <= 1'b0;
                                if (bit_cnt == 4'd7) begin
                                    state   <= ST_RNACK;
                                    bit_cnt <= 4'd8;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            ST_RNACK: begin
                                state    <= ST_STOP;
                                sda_oe_q <= 1'b1;
                            end
                            ST_STOP: begin
                                state    <= ST_IDLE;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                scl_oe_q <= 1'b0;
                                sda_oe_q <= 1'b0;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - self-checking bench with behavioural I2C slave and scoreboard
module tb_i2c_master_ctrl;
    import i2c_pkg::*;

    localparam int CLK_DIV     = 4;
    localparam int STRETCH_CYC = 10;
    localparam int WAIT_LIMIT  = 3000;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        logic       ack_addr;
        logic       ack_data;
        logic [7:0] srd;
        logic       stretch;
        logic       exp_ack_err;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic        ack_err;
        logic        chk_rdata;
        logic [7:0]  rdata;
        int          lat;
        logic [31:0] cap;
        int          nrise;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_master_ctrl_if bus_if ();

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vecs[5];

    logic        scl_hold = 1'b0;
    logic        slave_low = 1'b0;
    logic        cur_ack_addr = 1'b0, cur_ack_data = 1'b0, cur_stretch = 1'b0;
    logic [7:0]  cur_srd = 8'h00;
    logic        scl_line, sda_line;
    logic        s_scl, s_sda;
    logic        prev_scl = 1'b1, prev_sda = 1'b1;
    logic        rw_seen = 1'b0;
    logic [31:0] cap = '0;
    int          rise_cnt = 0;
    int          stretch_left = 0;

    int cyc = 0, rise_cyc = 0, last_lat = 0, done_count = 0, exp_dones = 0;
    logic prev_busy = 1'b0;

    assign scl_line      = !(bus_if.scl_oe || scl_hold);
    assign sda_line      = !(bus_if.sda_oe || slave_low);
    assign bus_if.scl_in = scl_line;
    assign bus_if.sda_in = sda_line;

    // Slave: ACKs, read data and a one-shot clock stretch, driven on SCL falling edges.
    always @(negedge clk) begin
        s_scl = scl_line;
        s_sda = sda_line;
        if (rst) begin
            rise_cnt = 0; cap = '0; slave_low = 1'b0; rw_seen = 1'b0;
            scl_hold = 1'b0; stretch_left = 0;
        end else if (prev_scl && s_scl && prev_sda && !s_sda) begin
            rise_cnt = 0; cap = '0; slave_low = 1'b0; rw_seen = 1'b0;
        end else begin
            if (!prev_scl && s_scl) begin
                if (rise_cnt == 7) rw_seen = s_sda;
                cap = {cap[30:0], s_sda};
                rise_cnt++;
            end
            if (prev_scl && !s_scl) begin
                slave_low = 1'b0;
                if (rise_cnt == 8)
                    slave_low = cur_ack_addr;
                else if (rise_cnt >= 9 && rise_cnt <= 16 && rw_seen && cur_ack_addr)
                    slave_low = !cur_srd[16 - rise_cnt];
                else if (rise_cnt == 17 && !rw_seen && cur_ack_addr)
                    slave_low = cur_ack_data;
                if (rise_cnt == 3 && cur_stretch) begin
                    scl_hold = 1'b1;
                    stretch_left = STRETCH_CYC;
                end
            end
            if (scl_hold && !bus_if.scl_oe) begin
                if (stretch_left == 0) scl_hold = 1'b0;
                else stretch_left--;
            end
        end
        prev_scl = s_scl;
        prev_sda = s_sda;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus_if.busy && !prev_busy) rise_cyc = cyc;
        if (bus_if.done) begin
            done_count++;
            last_lat = cyc - rise_cyc;
        end
        prev_busy = bus_if.busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void build_exp(input vec_t v, output logic [31:0] c, output int n);
        c = '0;
        n = 0;
        for (int i = 6; i >= 0; i--) begin c = {c[30:0], v.addr[i]}; n++; end
        c = {c[30:0], v.rw}; n++;
        c = {c[30:0], !v.ack_addr}; n++;
        if (v.ack_addr) begin
            for (int i = 7; i >= 0; i--) begin
                c = {c[30:0], v.rw ? v.srd[i] : v.wdata[i]}; n++;
            end
            c = {c[30:0], v.rw ? 1'b1 : !v.ack_data}; n++;
        end
        c = {c[30:0], 1'b0}; n++;
    endfunction

    task automatic launch(input vec_t v);
        exp_t e;
        cur_ack_addr = v.ack_addr;
        cur_ack_data = v.ack_data;
        cur_srd      = v.srd;
        cur_stretch  = v.stretch;
        e.ack_err    = v.exp_ack_err;
        e.chk_rdata  = v.rw && !v.exp_ack_err;
        e.rdata      = v.exp_rdata;
        e.lat        = v.exp_lat;
        build_exp(v, e.cap, e.nrise);
        sb.push_back(e);
        exp_dones++;
        @(negedge clk);
        bus_if.addr  = v.addr;
        bus_if.rw    = v.rw;
        bus_if.wdata = v.wdata;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        bit   seen = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus_if.done) seen = 1'b1;
        end
        if (sb.size() == 0) begin
            check({tag, "_unexpected_done"}, 32'(1), 32'(0));
            return;
        end
        e = sb.pop_front();
        if (!seen) begin
            check({tag, "_timeout"}, 32'(0), 32'(1));
            return;
        end
        check({tag, "_ack_err"}, 32'(bus_if.ack_err), 32'(e.ack_err));
        check({tag, "_latency"}, 32'(last_lat), 32'(e.lat));
        check({tag, "_sda_bits"}, cap, e.cap);
        check({tag, "_scl_rises"}, 32'(rise_cnt), 32'(e.nrise));
        if (e.chk_rdata)
            check({tag, "_rdata"}, 32'(bus_if.rdata), 32'(e.rdata));
    endtask

    initial begin
        bit reached;
        bus_if.start = 1'b0;
        bus_if.addr  = '0;
        bus_if.rw    = 1'b0;
        bus_if.wdata = '0;

        //           addr        rw    wdata  ackA  ackD  srd    str   aerr  rdata  lat
        vecs[0] = '{VADDR_DEV2, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 320};
        vecs[1] = '{7'h50,      1'b0, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 176};
        vecs[2] = '{VADDR_DEV1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 320};
        vecs[3] = '{VADDR_DEV2, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 330};
        vecs[4] = '{VADDR_DEV1, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 320};

        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({bus_if.scl_oe, bus_if.sda_oe, bus_if.busy, bus_if.done, bus_if.ack_err, bus_if.rdata}),
              32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            launch(vecs[i]);
            wait_done($sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
        end

        // Reset in the middle of the write-data byte.
        launch(vecs[0]);
        reached = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && !reached; i++) begin
            @(negedge clk);
            if (rise_cnt >= 12 && rise_cnt <= 16) reached = 1'b1;
        end
        check("midrst_reach_wdata", 32'(reached), 32'(1));
        rst = 1'b1;
        #1;
        check("midrst_outputs",
              32'({bus_if.scl_oe, bus_if.sda_oe, bus_if.busy, bus_if.done, bus_if.ack_err, bus_if.rdata}),
              32'(0));
        void'(sb.pop_back());
        exp_dones--;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        launch(vecs[0]);
        wait_done("post_rst");

        // Start while busy is ignored; start right after done is accepted.
        repeat (2) @(negedge clk);
        launch(vecs[0]);
        repeat (30) @(negedge clk);
        bus_if.addr  = 7'h50;
        bus_if.rw    = 1'b1;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_done("busy_start");
        launch(vecs[2]);
        #1;
        check("b2b_accept_busy", 32'(bus_if.busy), 32'(1));
        wait_done("b2b");
        repeat (60) @(negedge clk);
        check("done_count", 32'(done_count), 32'(exp_dones));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
